// File: rtl/regfile_ctrl_pkg.sv
// Shared types and helpers for the latch register-file port controller.
package regfile_ctrl_pkg;

  // Write sequencing states: setup -> latch strobe -> hold around each write.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wstate_e;

  // Requester identifiers; also the D-bus mux select value for that requester.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // One element of a one-hot decode of idx. Index 0 is the hardwired-zero
  // register, so it decodes to an all-zero vector.
  function automatic logic onehot_bit(input int idx, input int pos);
    return (idx != 0) && (idx == pos);
  endfunction

endpackage

// File: rtl/regfile_read_decoder.sv
// Registered one-hot read-port decoder with complementary tristate enables
// and a write-hazard flag aligned with the enables.
module regfile_read_decoder
  import regfile_ctrl_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    waddr,
  input  logic             busy,
  output logic [NREGS-1:0] ren,
  output logic [NREGS-1:0] nren,
  output logic             rhaz
);

  logic [NREGS-1:0] dec;

  // Combinational one-hot decode of the read address.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NREGS; k++) begin
      dec[k] = onehot_bit(int'(ra), k);
    end
  end

  // Register enables, complement and hazard so all three change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren  <= '0;
      nren <= '1;
      rhaz <= 1'b0;
    end else begin
      ren  <= dec;
      nren <= ~dec;
      rhaz <= busy && (waddr != '0) && (ra == waddr);
    end
  end

endmodule

// File: rtl/regfile_port_controller.sv
// Write-port arbiter and write sequencer for the latch-based register file,
// plus two registered read-port decoders.
//
// Handshake: a requester's write is taken on a rising edge where VALID and
// READY are both high. READY is combinational and only asserted in IDLE for
// the requester winning round-robin arbitration; VALID may drop before READY.
module regfile_port_controller
  import regfile_ctrl_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int AW         = $clog2(NREGS),
  parameter int STROBE_CYC = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             A_VALID,
  input  logic [AW-1:0]    A_ADDR,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [AW-1:0]    B_ADDR,
  output logic             B_READY,
  output logic             WD_SEL,
  output logic             WBUSY,
  output logic [NREGS-1:0] LE,
  output logic [NREGS-1:0] nLE,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  output logic [NREGS-1:0] REN1,
  output logic [NREGS-1:0] REN2,
  output logic [NREGS-1:0] nREN1,
  output logic [NREGS-1:0] nREN2,
  output logic             RHAZ1,
  output logic             RHAZ2,
  output logic [1:0]       dbg_state
);

  wstate_e          state, state_n;
  logic             last, last_n;
  logic             wd_sel_n;
  logic [AW-1:0]    waddr, waddr_n;
  logic [2:0]       cnt, cnt_n;
  logic             grant;
  logic             accept;
  logic             busy_n;
  logic [NREGS-1:0] le_d;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = REQ_A;
    if (A_VALID && B_VALID) begin
      grant = (last == REQ_B) ? REQ_A : REQ_B;
    end else if (B_VALID) begin
      grant = REQ_B;
    end
  end

  assign A_READY = nRST && (state == IDLE) && A_VALID && (grant == REQ_A);
  assign B_READY = nRST && (state == IDLE) && B_VALID && (grant == REQ_B);
  assign accept  = A_READY || B_READY;

  // Next-state logic for the write sequencer; r0 writes are absorbed in IDLE.
  always_comb begin
    state_n  = state;
    last_n   = last;
    wd_sel_n = WD_SEL;
    waddr_n  = waddr;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          waddr_n  = (grant == REQ_B) ? B_ADDR : A_ADDR;
          wd_sel_n = grant;
          last_n   = grant;
          state_n  = (waddr_n != '0) ? SETUP : IDLE;
        end
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = 3'(STROBE_CYC - 1);
      end
      STROBE: begin
        if (cnt == 3'd0) begin
          state_n = HOLD;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      HOLD: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Latch enable for the next cycle: only the target cell, only in STROBE.
  always_comb begin
    le_d = '0;
    for (int k = 0; k < NREGS; k++) begin
      le_d[k] = (state_n == STROBE) && onehot_bit(int'(waddr_n), k);
    end
  end

  assign busy_n = (state_n != IDLE);

  // Sequencer and arbitration state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last   <= REQ_B;
      WD_SEL <= REQ_A;
      waddr  <= '0;
      cnt    <= 3'd0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      WD_SEL <= wd_sel_n;
      waddr  <= waddr_n;
      cnt    <= cnt_n;
    end
  end

  // Registered complementary latch enables; reset closes every latch at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      LE  <= '0;
      nLE <= '1;
    end else begin
      LE  <= le_d;
      nLE <= ~le_d;
    end
  end

  assign WBUSY     = (state != IDLE);
  assign dbg_state = state;

  regfile_read_decoder #(.NREGS(NREGS), .AW(AW)) u_rd1 (
    .clk   (CLK),
    .rst_n (nRST),
    .ra    (RA1),
    .waddr (waddr_n),
    .busy  (busy_n),
    .ren   (REN1),
    .nren  (nREN1),
    .rhaz  (RHAZ1)
  );

  regfile_read_decoder #(.NREGS(NREGS), .AW(AW)) u_rd2 (
    .clk   (CLK),
    .rst_n (nRST),
    .ra    (RA2),
    .waddr (waddr_n),
    .busy  (busy_n),
    .ren   (REN2),
    .nren  (nREN2),
    .rhaz  (RHAZ2)
  );

endmodule
